// File: rtl/wb_dmem_slave_if.sv
// Bus bundle between the J1 data port (master) and the data-memory responder (slave).
interface wb_dmem_slave_if;
   logic        cyc_i;
   logic        we_i;
   logic [31:0] adr_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack_o;
   logic        err_o;

   modport slave (
      input  cyc_i, we_i, adr_i, dat_i,
      output dat_o, ack_o, err_o
   );

   modport master (
      output cyc_i, we_i, adr_i, dat_i,
      input  dat_o, ack_o, err_o
   );
endinterface

// File: rtl/wb_dmem_slave.sv
// Word-addressed data RAM behind the J1 cyc/we/adr/dat/ack port.
// Inserts WAIT_STATES wait cycles and returns a registered one-cycle ack.
// Out-of-range accesses still complete: the write is dropped, reads give 0,
// and err_o latches until reset.
module wb_dmem_slave #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_STATES = 1
) (
   input logic             clk,
   input logic             rst,
   wb_dmem_slave_if.slave  wb
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [3:0]            r_cnt;
   logic                  r_we;
   logic                  r_oor;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [31:0]           r_wdat;
   logic [31:0]           r_dat_o;
   logic                  r_ack;
   logic                  r_err;

   logic [31:0]           r_mem [0:(2**ADDR_WIDTH)-1];

   logic                  w_capture;
   logic                  w_access;
   logic                  w_acc_we;
   logic                  w_acc_oor;
   logic [ADDR_WIDTH-1:0] w_acc_idx;
   logic [31:0]           w_acc_dat;
   logic                  w_wr_en;
   logic                  w_rd_en;
   logic                  w_oor_in;
   logic [31:0]           w_rd_word;
   logic                  w_unused_adr_lo;

   // Byte-lane bits of the address carry no meaning for a word memory.
   assign w_unused_adr_lo = ^wb.adr_i[1:0];

   // Any set bit above the word index puts the access outside the RAM.
   assign w_oor_in  = (wb.adr_i >> (ADDR_WIDTH + 2)) != '0;
   assign w_rd_word = r_mem[w_acc_idx];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: capture in IDLE, count or abort in WAIT, ACK lasts one cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (wb.cyc_i) begin
               w_next = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!wb.cyc_i) begin
               w_next = S_IDLE;
            end else if (r_cnt == 4'd1) begin
               w_next = S_ACK;
            end
         end
         S_ACK:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Access controls for the ACK-entry edge. With zero wait states that edge
   // is also the capture edge, so the request comes straight from the bus
   // instead of the (not yet loaded) request registers.
   always_comb begin
      w_capture = (r_state == S_IDLE) && wb.cyc_i;
      w_access  = (w_next == S_ACK) && (r_state != S_ACK);
      if (r_state == S_IDLE) begin
         w_acc_we  = wb.we_i;
         w_acc_oor = w_oor_in;
         w_acc_idx = wb.adr_i[ADDR_WIDTH+1:2];
         w_acc_dat = wb.dat_i;
      end else begin
         w_acc_we  = r_we;
         w_acc_oor = r_oor;
         w_acc_idx = r_idx;
         w_acc_dat = r_wdat;
      end
      w_wr_en = w_access && w_acc_we && !w_acc_oor && !rst;
      w_rd_en = w_access && !w_acc_we && !w_acc_oor;
   end

   // Request registers and wait counter, loaded only at the IDLE capture edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_we   <= 1'b0;
         r_oor  <= 1'b0;
         r_idx  <= '0;
         r_wdat <= '0;
      end else if (w_capture) begin
         r_cnt  <= 4'(WAIT_STATES);
         r_we   <= wb.we_i;
         r_oor  <= w_oor_in;
         r_idx  <= wb.adr_i[ADDR_WIDTH+1:2];
         r_wdat <= wb.dat_i;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
         r_cnt  <= r_cnt - 4'd1;
      end
   end

   // Registered response: ack and data only for the ACK cycle, sticky range error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack   <= 1'b0;
         r_dat_o <= '0;
         r_err   <= 1'b0;
      end else begin
         r_ack   <= w_access;
         r_dat_o <= w_rd_en ? w_rd_word : '0;
         if (w_access && w_acc_oor) begin
            r_err <= 1'b1;
         end
      end
   end

   // RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_acc_idx] <= w_acc_dat;
      end
   end

   assign wb.ack_o = r_ack;
   assign wb.dat_o = r_dat_o;
   assign wb.err_o = r_err;

endmodule
